// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/done handshake, carry/overflow/error
// flags and an iterative shift-add multiplier (one partial product per cycle).
// An accepted request spends one cycle with its operands latched, then either
// finishes (single-cycle ops) or walks through WIDTH multiply steps.
module alu_seq #(
  parameter int WIDTH      = 16,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             input_CLK,
  input  logic             input_Reset,
  input  logic             input_Start,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [3:0]       input_ALUOp,
  output logic [WIDTH-1:0] output_ALU,
  output logic             output_Done,
  output logic             output_Busy,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Carry,
  output logic             output_Overflow,
  output logic             output_Error
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;

  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0] CNT_ONE  = SW'(1);

  // Control and operand state
  logic [1:0]         state_q, state_d;
  logic               pend_q, pend_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         op_q, op_d;

  // Multiplier datapath
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step;

  // Visible result and flags
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Single-cycle evaluation of the latched request
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [WIDTH:0]     sll_ext;
  logic [WIDTH:0]     srl_ext;
  logic [WIDTH:0]     sra_ext;
  logic               slt_bit;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_err;
  logic               accept;

  assign shamt = b_q[SW-1:0];

  // Evaluate every single-cycle op; the extra bit of each shift holds the last bit shifted out
  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    dif_ext = {1'b0, a_q} - {1'b0, b_q};
    sll_ext = {1'b0, a_q} << shamt;
    srl_ext = {a_q, 1'b0} >> shamt;
    sra_ext = $signed({a_q, 1'b0}) >>> shamt;
    slt_bit = ($signed(a_q) < $signed(b_q));
    alu_res = {WIDTH{1'b0}};
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: begin
        alu_res = sll_ext[WIDTH-1:0];
        alu_c   = sll_ext[WIDTH];
      end
      OP_SRL: begin
        alu_res = srl_ext[WIDTH:1];
        alu_c   = srl_ext[0];
      end
      OP_SRA: begin
        alu_res = sra_ext[WIDTH:1];
        alu_c   = sra_ext[0];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      // MUL only reaches this path when the multiplier is not built
      OP_MUL: alu_err = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state logic: accept requests, run the multiplier, publish results on entry to DONE
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    alu_d    = alu_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    accept   = input_Start && !pend_q && (state_q != ST_MUL);
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if ((op_q == OP_MUL) && (MUL_ENABLE != 1'b0)) begin
            state_d  = ST_MUL;
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a_q};
            mplier_d = b_q;
            cnt_d    = {SW{1'b0}};
          end else begin
            state_d = ST_DONE;
            alu_d   = alu_res;
            zero_d  = !alu_err && (alu_res == {WIDTH{1'b0}});
            neg_d   = !alu_err && alu_res[WIDTH-1];
            carry_d = alu_c;
            ovf_d   = alu_v;
            err_d   = alu_err;
          end
        end else if (accept) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
          a_d     = input_A;
          b_d     = input_B;
          op_d    = input_ALUOp;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          alu_d   = acc_step[WIDTH-1:0];
          zero_d  = (acc_step[WIDTH-1:0] == {WIDTH{1'b0}});
          neg_d   = acc_step[WIDTH-1];
          carry_d = |acc_step[2*WIDTH-1:WIDTH];
          ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_MUL);
  end

  // State registers; reset aborts any operation in flight and clears every output
  always_ff @(posedge input_CLK or posedge input_Reset) begin
    if (input_Reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 4'b0000;
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {SW{1'b0}};
      alu_q    <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      alu_q    <= alu_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign output_ALU      = alu_q;
  assign output_Done     = done_q;
  assign output_Busy     = busy_q;
  assign output_Zero     = zero_q;
  assign output_Negative = neg_q;
  assign output_Carry    = carry_q;
  assign output_Overflow = ovf_q;
  assign output_Error    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written multi-cycle sequences and
// randomized ops checked against an arithmetic reference model.
// Flag vectors are packed as {Zero, Negative, Carry, Overflow, Error}.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit instance with multiplier
  logic        start;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic [15:0] alu16;
  logic        done16, busy16, z16, n16, c16, v16, e16;

  // 8-bit instance
  logic        start8;
  logic [7:0]  a8, b8;
  logic [3:0]  op8;
  logic [7:0]  alu8;
  logic        done8, busy8, z8, n8, c8, v8, e8;

  // 16-bit instance without multiplier (shares a/b/op, own start)
  logic        start_nm;
  logic [15:0] alu_nm;
  logic        done_nm, busy_nm, z_nm, n_nm, c_nm, v_nm, e_nm;

  alu_seq #(.WIDTH(16), .MUL_ENABLE(1'b1)) dut16 (
    .input_CLK(clk), .input_Reset(rst), .input_Start(start),
    .input_A(a), .input_B(b), .input_ALUOp(op),
    .output_ALU(alu16), .output_Done(done16), .output_Busy(busy16),
    .output_Zero(z16), .output_Negative(n16), .output_Carry(c16),
    .output_Overflow(v16), .output_Error(e16));

  alu_seq #(.WIDTH(8), .MUL_ENABLE(1'b1)) dut8 (
    .input_CLK(clk), .input_Reset(rst), .input_Start(start8),
    .input_A(a8), .input_B(b8), .input_ALUOp(op8),
    .output_ALU(alu8), .output_Done(done8), .output_Busy(busy8),
    .output_Zero(z8), .output_Negative(n8), .output_Carry(c8),
    .output_Overflow(v8), .output_Error(e8));

  alu_seq #(.WIDTH(16), .MUL_ENABLE(1'b0)) dut_nm (
    .input_CLK(clk), .input_Reset(rst), .input_Start(start_nm),
    .input_A(a), .input_B(b), .input_ALUOp(op),
    .output_ALU(alu_nm), .output_Done(done_nm), .output_Busy(busy_nm),
    .output_Zero(z_nm), .output_Negative(n_nm), .output_Carry(c_nm),
    .output_Overflow(v_nm), .output_Error(e_nm));

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic [15:0] mux_alu;
  logic [4:0]  mux_flags;
  logic        mux_done, mux_busy;

  assign mux_alu   = (sel == 1) ? {8'h00, alu8} : (sel == 2) ? alu_nm : alu16;
  assign mux_flags = (sel == 1) ? {z8, n8, c8, v8, e8} :
                     (sel == 2) ? {z_nm, n_nm, c_nm, v_nm, e_nm} : {z16, n16, c16, v16, e16};
  assign mux_done  = (sel == 1) ? done8 : (sel == 2) ? done_nm : done16;
  assign mux_busy  = (sel == 1) ? busy8 : (sel == 2) ? busy_nm : busy16;

  typedef struct {
    int          s;
    logic [3:0]  o;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] ealu;
    logic [4:0]  efl;
    int          elat;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic st, input logic [3:0] o,
                       input logic [15:0] x, input logic [15:0] y);
    if (s == 1) begin
      start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else if (s == 2) begin
      start_nm = st; op = o; a = x; b = y;
    end else begin
      start = st; op = o; a = x; b = y;
    end
  endtask

  // Issue one op on instance s and wait (bounded) for its Done pulse.
  task automatic run_op(input int s, input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] ralu, output logic [4:0] rfl,
                        output int rlat, output int rbusy);
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, o, x, y);
    @(posedge clk); #1;
    drive(s, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
    rlat = -1; rbusy = 0; ralu = 'x; rfl = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mux_busy) rbusy++;
      if (mux_done) begin
        rlat = k; ralu = mux_alu; rfl = mux_flags;
        break;
      end
    end
  endtask

  // Reference model: the operation rules computed with plain integer arithmetic.
  function automatic logic [20:0] model16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int unsigned ua, ub, res;
    longint unsigned p;
    int sa, sb, s, sh;
    logic c, v, e, z, n;
    ua = 32'(x); ub = 32'(y); sa = $signed(x); sb = $signed(y);
    sh = int'(y[3:0]);
    res = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (o)
      4'd0: begin res = (ua + ub) & 32'hFFFF; c = (ua + ub) > 32'd65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1: begin res = (ua - ub) & 32'hFFFF; c = ua < ub; s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: res = ua & ub;
      4'd3: res = ua | ub;
      4'd4: res = ua ^ ub;
      4'd5: begin res = (ua << sh) & 32'hFFFF; c = (sh != 0) && (((ua >> (16 - sh)) & 32'd1) != 0); end
      4'd6: begin res = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 32'd1) != 0); end
      4'd7: begin res = 32'(sa >>> sh) & 32'hFFFF; c = (sh != 0) && (((ua >> (sh - 1)) & 32'd1) != 0); end
      4'd8: begin p = 64'(ua) * 64'(ub); res = 32'(p & 64'hFFFF); c = (p >> 16) != 0; v = c; end
      4'd9: res = (sa < sb) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    z = !e && (res == 0);
    n = !e && (((res >> 15) & 32'd1) != 0);
    return {res[15:0], z, n, c, v, e};
  endfunction

  logic [15:0] galu;
  logic [4:0]  gfl;
  int          glat, gbusy, dcount, bcount, first_done;
  logic [20:0] m;
  logic [3:0]  rop;
  logic [15:0] rx, ry;

  initial begin
    // sel, op, A, B, ALU, {Z,N,C,V,E}, latency
    tbl[0]  = '{0, 4'h0, 16'h1234, 16'h5678, 16'h68AC, 5'b00000, 1};
    tbl[1]  = '{0, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01010, 1};
    tbl[2]  = '{0, 4'h1, 16'h0000, 16'h0001, 16'hFFFF, 5'b01100, 1};
    tbl[3]  = '{0, 4'h8, 16'h00FF, 16'h0101, 16'hFFFF, 5'b01000, 17};
    tbl[4]  = '{0, 4'h8, 16'h1000, 16'h0010, 16'h0000, 5'b10110, 17};
    tbl[5]  = '{0, 4'h7, 16'h8001, 16'h0011, 16'hC000, 5'b01100, 1};
    tbl[6]  = '{0, 4'h5, 16'h8000, 16'h0000, 16'h8000, 5'b01000, 1};
    tbl[7]  = '{0, 4'h9, 16'hFFFF, 16'h0001, 16'h0001, 5'b00000, 1};
    tbl[8]  = '{0, 4'hF, 16'h1234, 16'h5678, 16'h0000, 5'b00001, 1};
    tbl[9]  = '{0, 4'h0, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 1};
    tbl[10] = '{0, 4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 5'b01000, 1};
    tbl[11] = '{0, 4'h3, 16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 1};
    tbl[12] = '{0, 4'h4, 16'hA5A5, 16'hA5A5, 16'h0000, 5'b10000, 1};
    tbl[13] = '{0, 4'h6, 16'h0009, 16'h0004, 16'h0000, 5'b10100, 1};
    tbl[14] = '{0, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00010, 1};
    tbl[15] = '{0, 4'h5, 16'h8001, 16'h0001, 16'h0002, 5'b00100, 1};
    tbl[16] = '{0, 4'h9, 16'h0001, 16'hFFFF, 16'h0000, 5'b10000, 1};
    tbl[17] = '{0, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b10100, 1};
    tbl[18] = '{0, 4'hA, 16'h0003, 16'h0004, 16'h0000, 5'b00001, 1};
    tbl[19] = '{1, 4'h0, 16'h007F, 16'h0001, 16'h0080, 5'b01010, 1};
    tbl[20] = '{1, 4'h8, 16'h000F, 16'h0011, 16'h00FF, 5'b01000, 9};
    tbl[21] = '{1, 4'h8, 16'h0010, 16'h0010, 16'h0000, 5'b10110, 9};
    tbl[22] = '{1, 4'h7, 16'h0081, 16'h0009, 16'h00C0, 5'b01100, 1};
    tbl[23] = '{2, 4'h8, 16'h0003, 16'h0005, 16'h0000, 5'b00001, 1};

    rst = 1'b1;
    start = 1'b0; a = 16'h0000; b = 16'h0000; op = 4'h0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; op8 = 4'h0;
    start_nm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_w16", {alu16, done16, busy16, z16, n16, c16, v16, e16}, 64'd0);
    chk("reset_w8", {alu8, done8, busy8, z8, n8, c8, v8, e8}, 64'd0);
    chk("reset_nomul", {alu_nm, done_nm, busy_nm, z_nm, n_nm, c_nm, v_nm, e_nm}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      run_op(tbl[i].s, tbl[i].o, tbl[i].x, tbl[i].y, galu, gfl, glat, gbusy);
      chk($sformatf("tbl%0d_alu", i), galu, tbl[i].ealu);
      chk($sformatf("tbl%0d_flags", i), gfl, tbl[i].efl);
      chk($sformatf("tbl%0d_latency", i), glat, tbl[i].elat);
      chk($sformatf("tbl%0d_busy_cycles", i), gbusy, tbl[i].elat - 1);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_pulse", i), mux_done, 1'b0);
    end
    sel = 0;

    // Start pulsed with a different op during MUL cycle 3 must be ignored
    @(negedge clk);
    drive(0, 1'b1, 4'h8, 16'h00FF, 16'h0101);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h8, 16'h00FF, 16'h0101);
    dcount = 0; first_done = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        dcount++;
        if (first_done < 0) begin
          first_done = k;
          chk("ignore_start_alu", alu16, 16'hFFFF);
          chk("ignore_start_flags", {z16, n16, c16, v16, e16}, 5'b01000);
        end
      end
      if (k == 3) drive(0, 1'b1, 4'h0, 16'h0001, 16'h0001);
      else drive(0, 1'b0, 4'h0, 16'h0001, 16'h0001);
    end
    chk("ignore_start_latency", first_done, 17);
    chk("ignore_start_done_count", dcount, 1);
    chk("ignore_start_alu_held", alu16, 16'hFFFF);

    // Start accepted in the Done cycle (back-to-back)
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 16'h0010, 16'h0020);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    chk("b2b_first_done", done16, 1'b1);
    chk("b2b_first_alu", alu16, 16'h0030);
    drive(0, 1'b1, 4'h1, 16'h0009, 16'h0003);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    chk("b2b_accept_no_done", done16, 1'b0);
    @(posedge clk); #1;
    chk("b2b_second_done", done16, 1'b1);
    chk("b2b_second_alu", alu16, 16'h0006);

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 11));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 4 == 0) ry = 16'($urandom_range(0, 16));
      m = model16(rop, rx, ry);
      run_op(0, rop, rx, ry, galu, gfl, glat, gbusy);
      chk($sformatf("rand%0d_op%0h_alu", i, rop), galu, m[20:5]);
      chk($sformatf("rand%0d_op%0h_flags", i, rop), gfl, m[4:0]);
      chk($sformatf("rand%0d_op%0h_latency", i, rop), glat, (rop == 4'h8) ? 17 : 1);
    end

    // Asynchronous reset in MUL cycle 5: outputs clear before the next edge, no Done follows
    run_op(0, 4'h0, 16'h0001, 16'h0001, galu, gfl, glat, gbusy);
    chk("pre_reset_alu", galu, 16'h0002);
    @(negedge clk);
    drive(0, 1'b1, 4'h8, 16'h0003, 16'h0005);
    @(posedge clk); #1;
    drive(0, 1'b0, 4'h0, 16'h0000, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_mul_busy", busy16, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {alu16, done16, busy16, z16, n16, c16, v16, e16}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0; bcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done16) dcount++;
      if (busy16) bcount++;
    end
    chk("post_reset_no_done", dcount, 0);
    chk("post_reset_no_busy", bcount, 0);
    chk("post_reset_alu", alu16, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
